// File: rtl/code_pkg.sv
// Shared types and default sizing for the count-code receive decoder.
`timescale 1ns/1ps
package code_pkg;
  localparam int unsigned CODE_W_DEF     = 64;
  localparam int unsigned LOCK_CNT_DEF   = 4;
  localparam int unsigned UNLOCK_CNT_DEF = 2;
  localparam int unsigned ERR_W_DEF      = 16;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } state_t;
endpackage

// File: rtl/code_dec_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
`timescale 1ns/1ps
module gray2bin #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] g_i,
  output logic [W-1:0] b_o
);
  always_comb begin
    b_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      b_o[i] = ^(g_i >> i);
    end
  end
endmodule

// File: rtl/code_dec.sv
// Dual-channel count-code receiver: channel select, Gray decode, sequence lock FSM, error counter.
// Optional cross-channel check enabled by defining CODE_DEC_XCHECK_EN (drives XErr).
`timescale 1ns/1ps
module code_dec
  import code_pkg::*;
#(
  parameter int unsigned W          = CODE_W_DEF,
  parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF,
  parameter int unsigned UNLOCK_CNT = UNLOCK_CNT_DEF,
  parameter int unsigned ERR_W      = ERR_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Slt,
  input  logic [W-1:0]     Code0,
  input  logic [W-1:0]     Code1,
  output logic [W-1:0]     Dout,
  output logic             Dvalid,
  output logic             Locked,
  output logic             Mismatch,
  output logic [ERR_W-1:0] ErrCnt,
  output logic             XErr
);
  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);

  logic [W-1:0]     s1_word_q;
  logic             s1_slt_q;
  logic             s1_v_q;
  logic [W-1:0]     dec_word;
  logic [W-1:0]     dout_q;
  logic             dvalid_q;
  state_t           state_q;
  logic [W-1:0]     exp_q;
  logic [GW-1:0]    good_q;
  logic [BW-1:0]    bad_q;
  logic             locked_q;
  logic             mism_q;
  logic [ERR_W-1:0] errcnt_q;
  logic             hit;

  gray2bin #(.W(W)) u_g2b_sel (
    .g_i (s1_word_q),
    .b_o (dec_word)
  );

  // Capture and decode stages
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_word_q <= '0;
      s1_slt_q  <= 1'b0;
      s1_v_q    <= 1'b0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
    end else begin
      s1_v_q <= En;
      if (En) begin
        s1_word_q <= Slt ? Code1 : Code0;
        s1_slt_q  <= Slt;
      end
      dvalid_q <= s1_v_q;
      dout_q   <= s1_slt_q ? dec_word : s1_word_q;
    end
  end

`ifdef CODE_DEC_XCHECK_EN
  logic [W-1:0] s1_c0_q;
  logic [W-1:0] s1_c1_q;
  logic [W-1:0] dec_c1;
  logic         xerr_q;

  gray2bin #(.W(W)) u_g2b_x (
    .g_i (s1_c1_q),
    .b_o (dec_c1)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_c0_q <= '0;
      s1_c1_q <= '0;
      xerr_q  <= 1'b0;
    end else begin
      if (En) begin
        s1_c0_q <= Code0;
        s1_c1_q <= Code1;
      end
      xerr_q <= s1_v_q && (s1_c0_q != dec_c1);
    end
  end

  assign XErr = xerr_q;
`else
  assign XErr = 1'b0;
`endif

  assign hit = (dout_q == exp_q);

  // Every valid word re-seeds the expected value, so a single jump costs one mismatch only
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= HUNT;
      exp_q    <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
      mism_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      mism_q <= 1'b0;
      if (dvalid_q) begin
        exp_q <= dout_q + 1'b1;
        unique case (state_q)
          HUNT: begin
            good_q  <= GW'(1);
            state_q <= SYNC;
          end
          SYNC: begin
            if (hit) begin
              good_q <= good_q + 1'b1;
              if (good_q == GW'(LOCK_CNT - 1)) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                bad_q    <= '0;
              end
            end else begin
              good_q <= GW'(1);
            end
          end
          LOCKED: begin
            if (hit) begin
              bad_q <= '0;
            end else begin
              mism_q <= 1'b1;
              if (errcnt_q != '1) errcnt_q <= errcnt_q + 1'b1;
              if (bad_q == BW'(UNLOCK_CNT - 1)) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
                bad_q    <= '0;
              end else begin
                bad_q <= bad_q + 1'b1;
              end
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Dout     = dout_q;
  assign Dvalid   = dvalid_q;
  assign Locked   = locked_q;
  assign Mismatch = mism_q;
  assign ErrCnt   = errcnt_q;
endmodule

// File: tb/tb_code_dec.sv
// Randomised scoreboard bench for code_dec; stimulus pushes reference results, a monitor pops them on Dvalid.
`timescale 1ns/1ps
module tb_code_dec;
  localparam int unsigned W          = 64;
  localparam int unsigned LOCK_CNT   = 4;
  localparam int unsigned UNLOCK_CNT = 2;
  localparam int unsigned ERR_W      = 16;
`ifdef CODE_DEC_XCHECK_EN
  localparam bit XC = 1'b1;
`else
  localparam bit XC = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             En = 1'b0;
  logic             Slt = 1'b0;
  logic [W-1:0]     Code0 = '0;
  logic [W-1:0]     Code1 = '0;
  logic [W-1:0]     Dout;
  logic             Dvalid;
  logic             Locked;
  logic             Mismatch;
  logic [ERR_W-1:0] ErrCnt;
  logic             XErr;

  code_dec #(
    .W(W), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(ERR_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Slt(Slt), .Code0(Code0), .Code1(Code1),
    .Dout(Dout), .Dvalid(Dvalid), .Locked(Locked), .Mismatch(Mismatch),
    .ErrCnt(ErrCnt), .XErr(XErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0]     dout;
    logic             xerr;
    logic             locked;
    logic             mism;
    logic [ERR_W-1:0] err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: state as "phase" (0 searching, 1 counting a run, 2 locked) plus run/miss counts
  int               m_phase;
  int               m_run;
  int               m_miss;
  logic [W-1:0]     m_prev;
  logic [ERR_W-1:0] m_err;
  logic [W-1:0]     cur;

  bit               pend = 1'b0;
  exp_t             pitem;
  logic             lastlock = 1'b0;
  logic [ERR_W-1:0] lasterr = '0;

  function automatic logic [W-1:0] gray(input logic [W-1:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [W-1:0] ungray(input logic [W-1:0] g);
    logic [W-1:0] b = '0;
    logic [W-1:0] t = g;
    while (t != '0) begin
      b = b ^ t;
      t = t >> 1;
    end
    return b;
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_miss = 0; m_prev = '0; m_err = '0;
  endtask

  task automatic send_raw(input logic en, input logic slt, input logic [W-1:0] c0, input logic [W-1:0] c1);
    exp_t e;
    logic [W-1:0] v;
    @(negedge Clk);
    En = en; Slt = slt; Code0 = c0; Code1 = c1;
    if (en) begin
      v = slt ? ungray(c1) : c0;
      e.dout = v;
      e.xerr = XC && (c0 != ungray(c1));
      e.mism = 1'b0;
      case (m_phase)
        0: begin m_phase = 1; m_run = 1; end
        1: begin
          if (v == m_prev + 1) begin
            m_run++;
            if (m_run == LOCK_CNT) begin m_phase = 2; m_miss = 0; end
          end else m_run = 1;
        end
        default: begin
          if (v == m_prev + 1) m_miss = 0;
          else begin
            e.mism = 1'b1;
            if (m_err != '1) m_err++;
            m_miss++;
            if (m_miss == UNLOCK_CNT) m_phase = 0;
          end
        end
      endcase
      m_prev = v;
      e.locked = (m_phase == 2);
      e.err = m_err;
      q.push_back(e);
    end
  endtask

  task automatic send(input logic [W-1:0] v, input logic slt, input bit junk);
    logic [W-1:0] c0 = v;
    logic [W-1:0] c1 = gray(v);
    if (junk) begin
      if (slt) c0 = rnd64(); else c1 = rnd64();
    end
    send_raw(1'b1, slt, c0, c1);
    cur = v + 1;
  endtask

  task automatic idle();
    send_raw(1'b0, 1'($urandom), rnd64(), rnd64());
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_Dout"},     Dout, '0);
    chk({tag, "_Dvalid"},   W'(Dvalid), '0);
    chk({tag, "_Locked"},   W'(Locked), '0);
    chk({tag, "_Mismatch"}, W'(Mismatch), '0);
    chk({tag, "_ErrCnt"},   W'(ErrCnt), '0);
    chk({tag, "_XErr"},     W'(XErr), '0);
  endtask

  task automatic pulse_reset(input int unsigned cycles);
    @(negedge Clk);
    Reset = 1'b1; En = 1'b0;
    q.delete();
    model_reset();
    #1 check_zero("reset");
    repeat (cycles) @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Monitor: pops on Dvalid; lock/mismatch/count are judged one edge later
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (Reset) begin
        pend = 1'b0; lastlock = 1'b0; lasterr = '0;
      end else begin
        if (pend) begin
          chk("Locked",   W'(Locked),   W'(pitem.locked));
          chk("Mismatch", W'(Mismatch), W'(pitem.mism));
          chk("ErrCnt",   W'(ErrCnt),   W'(pitem.err));
          lastlock = pitem.locked;
          lasterr  = pitem.err;
        end else begin
          chk("Mismatch_idle", W'(Mismatch), '0);
          chk("Locked_hold",   W'(Locked),   W'(lastlock));
          chk("ErrCnt_hold",   W'(ErrCnt),   W'(lasterr));
        end
        pend = 1'b0;
        if (Dvalid === 1'b1) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_Dvalid: actual=1 required=0 at %0t", $time);
          end else begin
            pitem = q.pop_front();
            chk("Dout", Dout, pitem.dout);
            chk("XErr", W'(XErr), W'(pitem.xerr));
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    int unsigned drain;
    model_reset();
    cur = '0;
    #1 Reset = 1'b1;
    #1 check_zero("por");
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    // binary count up to lock, then Gray continuation
    for (int unsigned v = 0; v < 4; v++) send(W'(v), 1'b0, 1'b0);
    send(64'd4, 1'b1, 1'b0);
    send(64'd5, 1'b1, 1'b0);
    for (int unsigned v = 6; v <= 10; v++) send(W'(v), 1'($urandom), 1'b0);
    // single jump then continuation
    send(64'd20, 1'b0, 1'b0);
    send(64'd21, 1'b0, 1'b0);
    send(64'd22, 1'b1, 1'b0);
    // two consecutive misses drop lock; relock on next run
    send(64'd50, 1'b0, 1'b0);
    send(64'd99, 1'b1, 1'b0);
    for (int unsigned v = 100; v <= 104; v++) send(W'(v), 1'b0, 1'b0);
    repeat (3) idle();
    #1;
    chk("pre_reset_ErrCnt", W'(ErrCnt), 64'd3);
    chk("pre_reset_Locked", W'(Locked), 64'd1);
    // reset with words in flight
    send(64'd105, 1'b0, 1'b0);
    send(64'd106, 1'b1, 1'b0);
    pulse_reset(3);

    // wrap and enable gaps
    send(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    idle();
    send(64'd0, 1'b0, 1'b0);
    idle();
    send(64'd1, 1'b1, 1'b0);
    send(64'd2, 1'b0, 1'b0);
    repeat (3) idle();
    #1;
    chk("wrap_Locked", W'(Locked), 64'd1);
    chk("wrap_ErrCnt", W'(ErrCnt), 64'd0);

    // cross-channel disagreement
    send_raw(1'b1, 1'b0, 64'd5, gray(64'd6));
    cur = 64'd6;

    for (int unsigned i = 0; i < 600; i++) begin
      r = $urandom % 32;
      if (r < 4) idle();
      else if (r == 4) send(rnd64(), 1'($urandom), 1'b0);
      else if (r == 5) send(64'hFFFF_FFFF_FFFF_FFF0 + W'($urandom % 8), 1'($urandom), 1'b0);
      else if (r == 6 && ($urandom % 8) == 0) pulse_reset(1 + $urandom % 3);
      else send(cur, 1'($urandom), ($urandom % 8) == 0);
    end

    drain = 0;
    while ((q.size() != 0 || pend) && drain < 20) begin
      idle();
      drain++;
    end
    repeat (2) @(negedge Clk);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: actual=%0d pending required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
